// File: rtl/serial_cpl_port.sv
// -----------------------------------------------------------------------------
// serial_cpl_port
//
// Word-level front end for the bit-serial two's-complement unit. Parallel
// words arrive over a valid/ready handshake and leave LSB-first on so_i, with
// a word-start marker on so_r that is high only alongside bit 0. The serial
// result returned on si_y is reassembled into a parallel word and compared
// against the arithmetic negation of the word that was sent.
//
// Parameters
//   W      word width in bits (2..32)
//   Y_LAT  cycles from so_i to the matching si_y (0..3)
//
// Ports
//   t_clk      in   1  clock, rising edge
//   r          in   1  synchronous active-high reset
//   in_valid   in   1  in_data valid
//   in_ready   out  1  port can accept a word
//   in_data    in   W  word to serialize
//   so_i       out  1  serial bit to complementer, LSB first
//   so_r       out  1  word-start marker, high with bit 0 only
//   si_y       in   1  serial bit returned by complementer
//   out_valid  out  1  one-cycle pulse, out_data/chk_err valid
//   out_data   out  W  reassembled returned word (held between pulses)
//   chk_err    out  1  with out_valid: out_data differs from negated word
//   err_cnt    out  8  saturating count of chk_err pulses
// -----------------------------------------------------------------------------
module serial_cpl_port #(
   parameter int W     = 12,
   parameter int Y_LAT = 0
) (
   input  logic         t_clk,
   input  logic         r,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         so_i,
   output logic         so_r,
   input  logic         si_y,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         chk_err,
   output logic [7:0]   err_cnt
);

   localparam int            CW       = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tx_state_e;

   // Two's-complement negation modulo 2^W.
   function automatic logic [W-1:0] negate(input logic [W-1:0] v);
      return ~v + W'(1);
   endfunction

   // Transmit side state
   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [W-1:0]  hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic [W-1:0]  exp_tx_q, exp_tx_d;
   logic [W-1:0]  exp_rx_q, exp_rx_d;
   logic          so_i_q, so_i_d;
   logic          so_r_q, so_r_d;

   // Capture side state
   logic [W-1:0]  rx_q, rx_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          chk_err_q, chk_err_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   logic          accept_s;
   logic [1:0]    tag_s;    // {bit_valid, last} for the bit on so_i this cycle
   logic [1:0]    dtag_s;   // same tag, aligned with si_y

   assign in_ready = !r && !hold_full_q;
   assign accept_s = in_valid && in_ready;

   assign so_i      = so_i_q;
   assign so_r      = so_r_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign chk_err   = chk_err_q;
   assign err_cnt   = err_cnt_q;

   // Transmit FSM: shifter/hold management, expected-value tracking, serial outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      exp_tx_d    = exp_tx_q;
      exp_rx_d    = exp_rx_q;
      so_i_d      = 1'b0;
      so_r_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               state_d     = ST_SHIFT;
               cnt_d       = '0;
               shreg_d     = hold_q;
               exp_tx_d    = negate(hold_q);
               hold_full_d = 1'b0;
            end else if (accept_s) begin
               state_d  = ST_SHIFT;
               cnt_d    = '0;
               shreg_d  = in_data;
               exp_tx_d = negate(in_data);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               // Expected value follows the finishing word to the capture side
               // before exp_tx is overwritten by the next load.
               exp_rx_d = exp_tx_q;
               if (hold_full_q) begin
                  cnt_d       = '0;
                  shreg_d     = hold_q;
                  exp_tx_d    = negate(hold_q);
                  hold_full_d = 1'b0;
                  if (accept_s) begin
                     hold_d      = in_data;
                     hold_full_d = 1'b1;
                  end else begin
                     hold_d = hold_q;
                  end
               end else if (accept_s) begin
                  cnt_d    = '0;
                  shreg_d  = in_data;
                  exp_tx_d = negate(in_data);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               shreg_d = shreg_q >> 1;
               cnt_d   = cnt_q + CW'(1);
               if (accept_s) begin
                  hold_d      = in_data;
                  hold_full_d = 1'b1;
               end else begin
                  hold_d = hold_q;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            hold_full_d = 1'b0;
         end
      endcase

      // Serial outputs are registered, so they are derived from next state.
      if (state_d == ST_SHIFT) begin
         so_i_d = shreg_d[0];
         so_r_d = (cnt_d == '0);
      end else begin
         so_i_d = 1'b0;
         so_r_d = 1'b0;
      end
   end

   // Transmit side registers.
   always_ff @(posedge t_clk) begin
      if (r) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         exp_tx_q    <= '0;
         exp_rx_q    <= '0;
         so_i_q      <= 1'b0;
         so_r_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         exp_tx_q    <= exp_tx_d;
         exp_rx_q    <= exp_rx_d;
         so_i_q      <= so_i_d;
         so_r_q      <= so_r_d;
      end
   end

   // The tag describes the bit currently on so_i; it is delayed to meet si_y.
   assign tag_s = {state_q == ST_SHIFT, cnt_q == CNT_LAST};

   if (Y_LAT == 0) begin : g_no_dly
      assign dtag_s = tag_s;
   end else begin : g_dly
      localparam int TW = 2 * Y_LAT;
      logic [TW-1:0] tag_pipe_q, tag_pipe_d;

      // Tag delay line, newest tag enters at the low end.
      always_comb begin
         tag_pipe_d = (tag_pipe_q << 2) | TW'(tag_s);
      end

      // Tag delay line registers; reset drops tags of any aborted word.
      always_ff @(posedge t_clk) begin
         if (r) begin
            tag_pipe_q <= '0;
         end else begin
            tag_pipe_q <= tag_pipe_d;
         end
      end

      assign dtag_s = tag_pipe_q[TW-1 -: 2];
   end

   // Capture side: reassemble returned bits, check and count errors.
   always_comb begin
      rx_d        = rx_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      chk_err_d   = 1'b0;
      err_cnt_d   = err_cnt_q;

      if (dtag_s[1]) begin
         // LSB arrives first, so bits enter at the MSB and move down.
         rx_d = {si_y, rx_q[W-1:1]};
         if (dtag_s[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = rx_d;
            // With Y_LAT=0 exp_rx is being loaded on this very edge, hence _d.
            chk_err_d   = (rx_d != exp_rx_d);
            if (chk_err_d && (err_cnt_q != 8'hFF)) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end else begin
               err_cnt_d = err_cnt_q;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         rx_d = rx_q;
      end
   end

   // Capture side registers.
   always_ff @(posedge t_clk) begin
      if (r) begin
         rx_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         chk_err_q   <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         rx_q        <= rx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         chk_err_q   <= chk_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_cpl_port.sv
// -----------------------------------------------------------------------------
// tb_serial_cpl_port
//
// Drives two serial_cpl_port instances (Y_LAT=0 and Y_LAT=2) with the same
// word stream. Each is looped through an ideal serial complementer model
// (the second through an extra 2-cycle delay); a fault switch replaces the
// complementer by a straight wire. Expected results go into one queue per
// instance when a word is accepted and are compared when out_valid pulses.
// -----------------------------------------------------------------------------
module tb_serial_cpl_port;

   localparam int W = 12;

   typedef struct {
      logic [11:0] data;
      logic        chk;
      logic [7:0]  err;
      int          cyc;
   } exp_t;

   logic        t_clk = 1'b0;
   logic        r;
   logic        in_valid;
   logic [11:0] in_data;
   logic        fault;

   logic        in_ready0, so_i0, so_r0, si_y0, out_valid0, chk_err0;
   logic [11:0] out_data0;
   logic [7:0]  err_cnt0;
   logic        in_ready1, so_i1, so_r1, si_y1, out_valid1, chk_err1;
   logic [11:0] out_data1;
   logic [7:0]  err_cnt1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   last_start = -1000;
   int   exp_err = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t e0, e1;

   // complementer models
   logic seen0_q = 1'b0, seen1_q = 1'b0;
   logic y0, y1, seen0_now, seen1_now, d1_q = 1'b0, d2_q = 1'b0;

   always #5 t_clk = ~t_clk;

   serial_cpl_port #(.W(W), .Y_LAT(0)) dut0 (
      .t_clk(t_clk), .r(r), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .so_i(so_i0), .so_r(so_r0), .si_y(si_y0),
      .out_valid(out_valid0), .out_data(out_data0), .chk_err(chk_err0),
      .err_cnt(err_cnt0));

   serial_cpl_port #(.W(W), .Y_LAT(2)) dut1 (
      .t_clk(t_clk), .r(r), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .so_i(so_i1), .so_r(so_r1), .si_y(si_y1),
      .out_valid(out_valid1), .out_data(out_data1), .chk_err(chk_err1),
      .err_cnt(err_cnt1));

   // Serial negation: output bit = input bit XOR (a 1 was seen earlier in the word).
   assign seen0_now = so_r0 ? 1'b0 : seen0_q;
   assign seen1_now = so_r1 ? 1'b0 : seen1_q;
   assign y0    = so_i0 ^ seen0_now;
   assign y1    = so_i1 ^ seen1_now;
   assign si_y0 = fault ? so_i0 : y0;
   assign si_y1 = d2_q;

   always @(posedge t_clk) begin
      cyc     <= cyc + 1;
      seen0_q <= seen0_now | so_i0;
      seen1_q <= seen1_now | so_i1;
      d1_q    <= fault ? so_i1 : y1;
      d2_q    <= d1_q;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   // Called at a negedge; leaves in_valid high and returns at the negedge after acceptance.
   task automatic push_word(input logic [11:0] w, output int e_acc);
      int   start;
      int   neg;
      exp_t e;
      bit   done = 1'b0;
      e_acc    = -1;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 100 && !done; i++) begin
         if (in_ready0) begin
            @(posedge t_clk);
            #1;
            e_acc = cyc;
            done  = 1'b1;
         end else begin
            @(negedge t_clk);
         end
      end
      if (!done) begin
         check_val("accept_timeout", {31'd0, in_ready0}, 32'd1);
      end else begin
         start      = (e_acc > last_start + W) ? e_acc : last_start + W;
         last_start = start;
         neg        = (4096 - int'(w)) % 4096;
         e.data     = fault ? w : 12'(neg);
         e.chk      = (int'(e.data) != neg);
         if (e.chk && exp_err < 255) exp_err++;
         e.err      = 8'(exp_err);
         e.cyc      = start + W;
         sb0.push_back(e);
         e.cyc      = start + W + 2;
         sb1.push_back(e);
         @(negedge t_clk);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge t_clk);
      check_val("drain0", sb0.size(), 0);
      check_val("drain1", sb1.size(), 0);
   endtask

   // Scoreboard for the Y_LAT=0 instance.
   always @(negedge t_clk) begin
      if (out_valid0) begin
         if (sb0.size() == 0) begin
            check_val("unexp_ov0", {31'd0, out_valid0}, 32'd0);
         end else begin
            e0 = sb0.pop_front();
            check_val("data0", out_data0, e0.data);
            check_val("chk0", chk_err0, e0.chk);
            check_val("err0", err_cnt0, e0.err);
            check_val("lat0", cyc, e0.cyc);
         end
      end
   end

   // Scoreboard for the Y_LAT=2 instance.
   always @(negedge t_clk) begin
      if (out_valid1) begin
         if (sb1.size() == 0) begin
            check_val("unexp_ov1", {31'd0, out_valid1}, 32'd0);
         end else begin
            e1 = sb1.pop_front();
            check_val("data1", out_data1, e1.data);
            check_val("chk1", chk_err1, e1.chk);
            check_val("err1", err_cnt1, e1.err);
            check_val("lat1", cyc, e1.cyc);
         end
      end
   end

   initial begin
      int          ea, eb, ec;
      logic [11:0] w;
      logic [11:0] tbl [4];
      tbl[0] = 12'h800; tbl[1] = 12'hFFF; tbl[2] = 12'h000; tbl[3] = 12'h7FF;
      r = 1'b1; in_valid = 1'b0; in_data = 12'h000; fault = 1'b0;

      // reset held 3 cycles
      repeat (3) @(negedge t_clk);
      check_val("rst_so_i", so_i0, 0);
      check_val("rst_so_r", so_r0, 0);
      check_val("rst_ov", out_valid0, 0);
      check_val("rst_od", out_data0, 0);
      check_val("rst_chk", chk_err0, 0);
      check_val("rst_err", err_cnt0, 0);
      check_val("rst_rdy", in_ready0, 0);
      r = 1'b0;
      @(negedge t_clk);
      check_val("rdy_after_rst", in_ready0, 1);

      // single word 0x001: bit pattern and marker
      push_word(12'h001, ea);
      in_valid = 1'b0;
      for (int k = 0; k < W; k++) begin
         check_val("so_i_001", so_i0, (k == 0));
         check_val("so_r_001", so_r0, (k == 0));
         check_val("so_i1_001", so_i1, (k == 0));
         @(negedge t_clk);
      end
      wait_drain();

      // back-to-back 0x0A5, 0x800 with no gap
      push_word(12'h0A5, ea);
      check_val("so_r_b2b_a", so_r0, 1);
      push_word(12'h800, eb);
      in_valid = 1'b0;
      for (int i = 0; i < 30 && cyc < ea + W; i++) begin
         if (cyc == ea + W - 1) check_val("so_r_b2b_last", so_r0, 0);
         @(negedge t_clk);
      end
      check_val("so_r_b2b_b", so_r0, 1);
      wait_drain();

      // three words continuously: second waits in hold
      push_word(12'h3C7, ea);
      push_word(12'h001, eb);
      check_val("rdy_hold_full", in_ready0, 0);
      push_word(12'h7FF, ec);
      in_valid = 1'b0;
      wait_drain();

      // fault injection: complementer bypassed
      fault = 1'b1;
      push_word(12'h004, ea);
      in_valid = 1'b0;
      wait_drain();
      push_word(12'h000, ea);
      in_valid = 1'b0;
      wait_drain();
      check_val("err_sticky", err_cnt0, 1);
      fault = 1'b0;

      // reset while bit 5 is on so_i, with a second word held
      push_word(12'h5A3, ea);
      push_word(12'h2B4, eb);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && cyc < ea + 5; i++) @(negedge t_clk);
      check_val("so_i_bit5", so_i0, 1);
      check_val("so_i1_bit5", so_i1, 1);
      r = 1'b1;
      @(negedge t_clk);
      sb0.delete();
      sb1.delete();
      exp_err    = 0;
      last_start = -1000;
      check_val("abort_so_i0", so_i0, 0);
      check_val("abort_so_r0", so_r0, 0);
      check_val("abort_so_i1", so_i1, 0);
      check_val("abort_so_r1", so_r1, 0);
      check_val("abort_ov1", out_valid1, 0);
      check_val("abort_err", err_cnt0, 0);
      r = 1'b0;
      @(negedge t_clk);
      push_word(12'h123, ea);
      in_valid = 1'b0;
      wait_drain();

      // boundary and random words with random gaps
      for (int i = 0; i < 10; i++) begin
         w = (i < 4) ? tbl[i] : 12'($urandom_range(0, 4095));
         push_word(w, ea);
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(negedge t_clk);
         end
      end
      in_valid = 1'b0;
      wait_drain();
      repeat (5) @(negedge t_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
